// File: rtl/dino_jump.sv
// Vertical-motion controller for the dino sprite: turns a jump press into a
// tick-paced rise / hang / fall trajectory and freezes while the dino is dead.
module dino_jump #(
    parameter int GROUND_V    = 320,
    parameter int JUMP_HEIGHT = 80,
    parameter int RISE_STEP   = 4,
    parameter int FALL_STEP   = 4,
    parameter int HANG_TICKS  = 8,
    parameter int TICK_DIV    = 500000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_jump,
    input  logic       is_alive,
    output logic [9:0] dino_v,
    output logic       airborne,
    output logic       tick
);

    localparam int CW   = $clog2(TICK_DIV);
    localparam int HW   = $clog2(HANG_TICKS + 2);
    localparam int APEX = GROUND_V - JUMP_HEIGHT;

    localparam logic [9:0]    GROUND_10   = 10'(GROUND_V);
    localparam logic [9:0]    APEX_10     = 10'(APEX);
    localparam logic [9:0]    RISE_10     = 10'(RISE_STEP);
    localparam logic [10:0]   RISE_LIM_11 = 11'(APEX + RISE_STEP);
    localparam logic [10:0]   GROUND_11   = 11'(GROUND_V);
    localparam logic [10:0]   FALL_11     = 11'(FALL_STEP);
    localparam logic [9:0]    LAUNCH_10   = (RISE_STEP >= JUMP_HEIGHT) ? 10'(APEX)
                                                                       : 10'(GROUND_V - RISE_STEP);
    localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HANG_LAST   = HW'(HANG_TICKS);

    typedef enum logic [1:0] {
        S_GROUND = 2'd0,
        S_RISE   = 2'd1,
        S_HANG   = 2'd2,
        S_FALL   = 2'd3
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync2_q, prev_q;
    logic          btn_rise;
    state_t        state_q;
    logic [9:0]    v_q;
    logic [HW-1:0] hang_q, hang_d;
    logic          air_q, pend_q;
    logic [9:0]    rise_d, fall_d;
    logic [10:0]   fall_sum;
    logic          near_apex, lands, hang_done;

    assign tick     = (cnt_q == TICK_LAST);
    assign cnt_d    = tick ? '0 : cnt_q + CW'(1);
    assign btn_rise = sync2_q & ~prev_q;

    // Step arithmetic is done one bit wider so overshoot clamps instead of wrapping.
    assign near_apex = ({1'b0, v_q} <= RISE_LIM_11);
    assign rise_d    = near_apex ? APEX_10 : v_q - RISE_10;
    assign fall_sum  = {1'b0, v_q} + FALL_11;
    assign lands     = (fall_sum >= GROUND_11);
    assign fall_d    = lands ? GROUND_10 : fall_sum[9:0];
    assign hang_d    = hang_q + HW'(1);
    assign hang_done = (hang_d >= HANG_LAST);

    assign dino_v   = v_q;
    assign airborne = air_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_jump;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_GROUND;
            v_q     <= GROUND_10;
            hang_q  <= '0;
            air_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else if (!is_alive) begin
            pend_q <= 1'b0;
        end else if (tick) begin
            case (state_q)
                S_GROUND: begin
                    if (pend_q) begin
                        state_q <= S_RISE;
                        v_q     <= LAUNCH_10;
                        air_q   <= 1'b1;
                        pend_q  <= 1'b0;
                    end else if (btn_rise) begin
                        pend_q <= 1'b1;
                    end
                end
                S_RISE: begin
                    v_q <= rise_d;
                    if (near_apex) begin
                        state_q <= S_HANG;
                        hang_q  <= '0;
                    end
                end
                S_HANG: begin
                    hang_q <= hang_d;
                    if (hang_done) begin
                        state_q <= S_FALL;
                    end
                end
                S_FALL: begin
                    v_q <= fall_d;
                    if (lands) begin
                        state_q <= S_GROUND;
                        air_q   <= 1'b0;
                    end
                end
                default: state_q <= S_GROUND;
            endcase
        end else if (state_q == S_GROUND && btn_rise) begin
            pend_q <= 1'b1;
        end
    end

endmodule
